// File: rtl/pe_row_mac_acc_if.sv
// pe_row_mac_acc_if: weight load, data beat, forward and result bus.
// master drives inputs of the row, slave is the PE row itself.
interface pe_row_mac_acc_if #(
  parameter int NUM_PE = 32,
  parameter int IN_W   = 7,
  parameter int W_W    = 7,
  parameter int ACC_W  = 24
);
  logic                   wt_load;
  logic [NUM_PE*W_W-1:0]  wt_in;
  logic                   in_valid;
  logic                   in_last;
  logic [NUM_PE*IN_W-1:0] data_in;
  logic [NUM_PE*IN_W-1:0] data_fwd;
  logic                   fwd_valid;
  logic                   out_valid;
  logic [ACC_W-1:0]       out_data;

  modport master (
    output wt_load, wt_in, in_valid, in_last, data_in,
    input  data_fwd, fwd_valid, out_valid, out_data
  );

  modport slave (
    input  wt_load, wt_in, in_valid, in_last, data_in,
    output data_fwd, fwd_valid, out_valid, out_data
  );
endinterface

// File: rtl/pe_row_mac_acc.sv
// pe_row_mac_acc: NUM_PE-lane MAC row, pipelined adder tree, group acc.
// Optional PE_ROW_ACC_SAT_EN: saturating accumulator instead of wrap.
module pe_row_mac_acc #(
  parameter int NUM_PE = 32,
  parameter int IN_W   = 7,
  parameter int W_W    = 7,
  parameter int ACC_W  = 24
) (
  input logic              clk,
  input logic              rst,
  pe_row_mac_acc_if.slave  bus
);
  localparam int L      = $clog2(NUM_PE);
  localparam int PROD_W = IN_W + W_W;
  localparam int SUM_W  = PROD_W + L;
  localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  logic [NUM_PE*W_W-1:0]  r_wt;
  logic [NUM_PE*IN_W-1:0] r_fwd;
  logic                   r_fvld;
  logic [L:0]             r_vld;
  logic [L:0]             r_lst;
  // leaves at [0..NUM_PE-1]; node NUM_PE+n sums nodes 2n and 2n+1
  logic signed [SUM_W-1:0] r_node [2*NUM_PE-1];
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out;
  logic                    r_first;
  logic                    r_ov;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_next;
`ifdef PE_ROW_ACC_SAT_EN
  logic signed [EXT_W-1:0] w_wide;
  logic [EXT_W-ACC_W:0]    w_top;
`endif

  assign bus.data_fwd  = r_fwd;
  assign bus.fwd_valid = r_fvld;
  assign bus.out_valid = r_ov;
  assign bus.out_data  = r_out;
  assign w_sum         = r_node[2*NUM_PE-2];

  // stationary weight bank, replaced only on wt_load
  always_ff @(posedge clk) begin
    if (rst) r_wt <= '0;
    else if (bus.wt_load) r_wt <= bus.wt_in;
  end

  // one-cycle data forward to the next row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd  <= '0;
      r_fvld <= 1'b0;
    end else begin
      r_fwd  <= bus.data_in;
      r_fvld <= bus.in_valid;
    end
  end

  // valid/last travel alongside products and tree levels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[L-1:0], bus.in_valid};
      r_lst <= {r_lst[L-1:0], bus.in_valid & bus.in_last};
    end
  end

  // lane products then one registered adder level per tree depth
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2*NUM_PE-1; n++) r_node[n] <= '0;
    end else begin
      for (int i = 0; i < NUM_PE; i++)
        r_node[i] <= SUM_W'(
          PROD_W'($signed(bus.data_in[i*IN_W +: IN_W])) *
          PROD_W'($signed(r_wt[i*W_W +: W_W])));
      for (int n = 0; n < NUM_PE-1; n++)
        r_node[NUM_PE+n] <= r_node[2*n] + r_node[2*n+1];
    end
  end

  // next accumulator value: fresh group restarts from zero
  always_comb begin
    w_base = r_first ? '0 : r_acc;
`ifdef PE_ROW_ACC_SAT_EN
    w_wide = EXT_W'(w_base) + EXT_W'(w_sum);
    w_top  = w_wide[EXT_W-1:ACC_W-1];
    w_next = w_wide[ACC_W-1:0];
    if (!((&w_top) || !(|w_top)))
      w_next = w_wide[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
`else
    w_next = w_base + ACC_W'(w_sum);
`endif
  end

  // group accumulator and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_out   <= '0;
      r_first <= 1'b1;
      r_ov    <= 1'b0;
    end else begin
      r_ov <= r_vld[L] & r_lst[L];
      if (r_vld[L]) begin
        r_acc   <= w_next;
        r_first <= r_lst[L];
        if (r_lst[L]) r_out <= w_next;
      end
    end
  end
endmodule
